// File: rtl/ol_walker.sv
// ol_walker -- Object List walker for one tile.
//
// Fetches OL words from VRAM one at a time, follows block links, skips
// empty strips and reserved words, and hands each primitive entry to
// isp_parser as opb_word/poly_addr with a one-cycle render_poly pulse.
// After issuing an entry it waits for poly_drawn before fetching the next.
//
// Ports:
//   clock, reset                 single clock, async active-high reset
//   ol_start, ol_addr            begin a walk at ol_addr (word aligned)
//   param_base                   byte base of the ISP/TSP parameter buffer
//   ol_abort                     stop the walk (deferred while waiting on isp_parser)
//   ol_vram_rd/addr, ol_vram_din VRAM read port, data one cycle after the strobe
//   opb_word, poly_addr          current entry and its parameter address
//   render_poly, poly_drawn      handshake with isp_parser
//   ol_busy, ol_done, ol_error   status; ol_error is the watchdog flag
//
// Optional feature: define OL_WATCHDOG_EN to add an entry counter that
// ends the walk with ol_error after MAX_ENTRIES decodes (link-loop guard).
// Without it ol_error is tied low and MAX_ENTRIES is unused.

module ol_walker #(
  parameter int MAX_ENTRIES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ol_start,
  input  logic [23:0] ol_addr,
  input  logic [23:0] param_base,
  input  logic        ol_abort,
  output logic        ol_vram_rd,
  output logic [23:0] ol_vram_addr,
  input  logic [31:0] ol_vram_din,
  output logic [31:0] opb_word,
  output logic [23:0] poly_addr,
  output logic        render_poly,
  input  logic        poly_drawn,
  output logic        ol_busy,
  output logic        ol_done,
  output logic        ol_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] opb_q, opb_d;
  logic [23:0] paddr_q, paddr_d;
  logic        rd_q, rd_d;
  logic        render_q, render_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pend_q, pend_d;     // abort seen while isp_parser owns an entry

`ifdef OL_WATCHDOG_EN
  localparam logic [12:0] MAX_CNT = 13'(MAX_ENTRIES);
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] cnt_inc;
  logic        err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{13'(MAX_ENTRIES)};
`endif

  logic unused_bits;
  assign unused_bits = ^ol_addr[1:0];

  // Entry classification helpers
  logic [31:0] din;
  logic        is_issue, is_skip, is_link, is_eol;
  assign din = ol_vram_din;

  always_comb begin
    is_issue = 1'b0;
    is_skip  = 1'b0;
    is_link  = 1'b0;
    is_eol   = 1'b0;
    if (!din[31]) begin
      // Strip with an empty mask carries no triangles.
      if (din[30:25] == 6'd0) is_skip  = 1'b1;
      else                    is_issue = 1'b1;
    end else begin
      case (din[30:29])
        2'b00, 2'b01: is_issue = 1'b1;   // tri / quad array
        2'b10:        is_skip  = 1'b1;   // reserved
        default: begin
          if (din[28]) is_eol  = 1'b1;
          else         is_link = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    opb_d   = opb_q;
    paddr_d = paddr_q;
    pend_d  = pend_q;
`ifdef OL_WATCHDOG_EN
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 13'd1;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Start wins over a simultaneous abort.
        if (ol_start) begin
          addr_d  = {ol_addr[23:2], 2'b00};
          pend_d  = 1'b0;
`ifdef OL_WATCHDOG_EN
          cnt_d   = 13'd0;
          err_d   = 1'b0;
`endif
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = ol_abort ? S_IDLE : S_DECODE;
      end

      S_DECODE: begin
        if (ol_abort) begin
          state_d = S_IDLE;
        end else begin
          if (is_issue) begin
            opb_d   = din;
            // Computed once here; later param_base changes do not affect it.
            paddr_d = param_base + {1'b0, din[20:0], 2'b00};
            state_d = S_ISSUE;
          end else if (is_link) begin
            addr_d  = {din[23:2], 2'b00};
            state_d = S_FETCH;
          end else if (is_eol) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 24'd4;
            state_d = S_FETCH;
          end
`ifdef OL_WATCHDOG_EN
          cnt_d = cnt_inc;
          // Limit reached without end-of-list: stop without issuing.
          if (!is_eol && cnt_inc >= MAX_CNT) begin
            err_d   = 1'b1;
            opb_d   = opb_q;
            paddr_d = paddr_q;
            addr_d  = addr_q;
            state_d = S_DONE;
          end
`endif
        end
      end

      S_ISSUE: begin
        state_d = ol_abort ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        // Abort here is deferred so isp_parser always finishes its entry.
        pend_d = pend_q | ol_abort;
        if (poly_drawn) begin
          if (pend_q || ol_abort) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 24'd4;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rd_d     = (state_d == S_FETCH);
    render_d = (state_d == S_ISSUE);
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 24'd0;
      opb_q    <= 32'd0;
      paddr_q  <= 24'd0;
      rd_q     <= 1'b0;
      render_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
`ifdef OL_WATCHDOG_EN
      cnt_q    <= 13'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      opb_q    <= opb_d;
      paddr_q  <= paddr_d;
      rd_q     <= rd_d;
      render_q <= render_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
`ifdef OL_WATCHDOG_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign ol_vram_rd   = rd_q;
  assign ol_vram_addr = addr_q;
  assign opb_word     = opb_q;
  assign poly_addr    = paddr_q;
  assign render_poly  = render_q;
  assign ol_busy      = busy_q;
  assign ol_done      = done_q;
`ifdef OL_WATCHDOG_EN
  assign ol_error     = err_q;
`else
  assign ol_error     = 1'b0;
`endif

endmodule

// File: tb/tb_ol_walker.sv
module tb_ol_walker;

  logic        clock = 1'b0;
  logic        reset;
  logic        ol_start, ol_abort, poly_drawn;
  logic [23:0] ol_addr, param_base;
  logic        ol_vram_rd;
  logic [23:0] ol_vram_addr;
  logic [31:0] ol_vram_din;
  logic [31:0] opb_word;
  logic [23:0] poly_addr;
  logic        render_poly, ol_busy, ol_done, ol_error;

  int n_chk = 0;
  int n_err = 0;
  int n_rd = 0, n_render = 0, n_done = 0;
  int r0, d0, rr0;

  logic [31:0] mem [int];

  always #5 clock = ~clock;

  ol_walker #(.MAX_ENTRIES(4)) dut (
    .clock(clock), .reset(reset), .ol_start(ol_start), .ol_addr(ol_addr),
    .param_base(param_base), .ol_abort(ol_abort), .ol_vram_rd(ol_vram_rd),
    .ol_vram_addr(ol_vram_addr), .ol_vram_din(ol_vram_din), .opb_word(opb_word),
    .poly_addr(poly_addr), .render_poly(render_poly), .poly_drawn(poly_drawn),
    .ol_busy(ol_busy), .ol_done(ol_done), .ol_error(ol_error)
  );

  // VRAM model: data one cycle after the strobe; unknown words end the list.
  function automatic logic [31:0] rd_mem(input logic [23:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 32'hF000_0000;
  endfunction

  always @(posedge clock) begin
    if (ol_vram_rd) ol_vram_din <= rd_mem(ol_vram_addr);
    if (ol_vram_rd) n_rd <= n_rd + 1;
    if (render_poly) n_render <= n_render + 1;
    if (ol_done) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic start(input logic [23:0] a);
    ol_addr = a; ol_start = 1'b1;
    tick();
    ol_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (ol_done) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; ol_start = 1'b0; ol_abort = 1'b0; poly_drawn = 1'b0;
    ol_addr = 24'd0; param_base = 24'h100000; ol_vram_din = 32'd0;

    mem[32'h001000] = 32'h0A00_0010;
    mem[32'h001004] = 32'hE000_2000;
    mem[32'h002000] = 32'hF000_0000;
    mem[32'hFFFFFC] = 32'hC000_0000;
    mem[32'h000000] = 32'h0000_0020;
    mem[32'h000004] = 32'hF000_0000;
    mem[32'h004000] = 32'h8000_0005;
    mem[32'h005000] = 32'hA000_0003;
    mem[32'h006000] = 32'hF000_0000;
    mem[32'h007000] = 32'hE000_7000;

    // Reset state
    tick(2);
    chk("rst_rd", {31'd0, ol_vram_rd}, 0);
    chk("rst_addr", {8'd0, ol_vram_addr}, 0);
    chk("rst_opb", opb_word, 0);
    chk("rst_paddr", {8'd0, poly_addr}, 0);
    chk("rst_render", {31'd0, render_poly}, 0);
    chk("rst_busy", {31'd0, ol_busy}, 0);
    chk("rst_done", {31'd0, ol_done}, 0);
    chk("rst_err", {31'd0, ol_error}, 0);
    reset = 1'b0;
    tick();

    // 1: strip issue with exact latency, start-while-busy ignored
    rr0 = n_render;
    start(24'h001000);
    chk("t1_rd", {31'd0, ol_vram_rd}, 1);
    chk("t1_addr", {8'd0, ol_vram_addr}, 32'h001000);
    chk("t1_busy", {31'd0, ol_busy}, 1);
    tick();
    chk("t1_dec_rd", {31'd0, ol_vram_rd}, 0);
    tick();
    chk("t1_render", {31'd0, render_poly}, 1);
    chk("t1_opb", opb_word, 32'h0A00_0010);
    chk("t1_paddr", {8'd0, poly_addr}, 32'h100040);
    tick();
    chk("t1_render_off", {31'd0, render_poly}, 0);
    start(24'h009000);
    tick();
    chk("t1_wait_rd", {31'd0, ol_vram_rd}, 0);
    chk("t1_wait_busy", {31'd0, ol_busy}, 1);
    chk("t1_hold_opb", opb_word, 32'h0A00_0010);
    poly_drawn = 1'b1;
    tick();
    poly_drawn = 1'b0;
    chk("t1_next_rd", {31'd0, ol_vram_rd}, 1);
    chk("t1_next_addr", {8'd0, ol_vram_addr}, 32'h001004);

    // 2: link then end-of-list
    tick(2);
    chk("t2_link_rd", {31'd0, ol_vram_rd}, 1);
    chk("t2_link_addr", {8'd0, ol_vram_addr}, 32'h002000);
    tick(2);
    chk("t2_done", {31'd0, ol_done}, 1);
    chk("t2_done_busy", {31'd0, ol_busy}, 1);
    tick();
    chk("t2_done_off", {31'd0, ol_done}, 0);
    chk("t2_idle_busy", {31'd0, ol_busy}, 0);
    chk("t2_renders", n_render - rr0, 1);

    // 3: reserved at top of memory wraps to 0, empty strip skipped
    rr0 = n_render;
    start(24'hFFFFFE);
    chk("t3_addr0", {8'd0, ol_vram_addr}, 32'hFFFFFC);
    tick(2);
    chk("t3_wrap_rd", {31'd0, ol_vram_rd}, 1);
    chk("t3_wrap_addr", {8'd0, ol_vram_addr}, 32'h000000);
    tick(2);
    chk("t3_skip_rd", {31'd0, ol_vram_rd}, 1);
    chk("t3_skip_addr", {8'd0, ol_vram_addr}, 32'h000004);
    wait_done("t3_done");
    chk("t3_renders", n_render - rr0, 0);
    tick();

    // 4: abort deferred in WAIT, immediate in FETCH
    start(24'h004000);
    tick(2);
    chk("t4_paddr", {8'd0, poly_addr}, 32'h100014);
    tick();
    ol_abort = 1'b1;
    tick();
    ol_abort = 1'b0;
    tick();
    chk("t4_wait_busy", {31'd0, ol_busy}, 1);
    chk("t4_wait_rd", {31'd0, ol_vram_rd}, 0);
    r0 = n_rd; d0 = n_done;
    poly_drawn = 1'b1;
    tick();
    poly_drawn = 1'b0;
    chk("t4_idle", {31'd0, ol_busy}, 0);
    tick(5);
    chk("t4_no_rd", n_rd - r0, 0);
    chk("t4_no_done", n_done - d0, 0);
    start(24'h004000);
    ol_abort = 1'b1;
    tick();
    ol_abort = 1'b0;
    chk("t4_fetch_abort", {31'd0, ol_busy}, 0);
    tick(2);

    // 6: reset mid-WAIT, then start+abort together in IDLE
    start(24'h005000);
    tick(3);
    chk("t6_wait", {31'd0, ol_busy}, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", {31'd0, ol_busy}, 0);
    chk("t6_rst_opb", opb_word, 0);
    chk("t6_rst_paddr", {8'd0, poly_addr}, 0);
    chk("t6_rst_render", {31'd0, render_poly}, 0);
    reset = 1'b0;
    tick();
    ol_abort = 1'b1;
    start(24'h006000);
    ol_abort = 1'b0;
    chk("t6_rd", {31'd0, ol_vram_rd}, 1);
    chk("t6_addr", {8'd0, ol_vram_addr}, 32'h006000);
    wait_done("t6_done");
    tick();

`ifdef OL_WATCHDOG_EN
    // 5: self-link loop caught after 4 decodes
    r0 = n_rd;
    start(24'h007000);
    wait_done("t5_done");
    chk("t5_err", {31'd0, ol_error}, 1);
    chk("t5_fetches", n_rd - r0, 4);
    tick(2);
    chk("t5_err_sticky", {31'd0, ol_error}, 1);
    start(24'h006000);
    chk("t5_err_clr", {31'd0, ol_error}, 0);
    tick(3);
`else
    chk("no_wd_err", {31'd0, ol_error}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
